// File: rtl/ex_wb_buffer_pkg.sv
// Shared datapath definitions for the EX->WB result buffer: widths, zero register,
// and the packed layout of one buffered result.
package ex_wb_buffer_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned NPC_W    = 64;
  localparam int unsigned RESULT_W = 64;
  localparam int unsigned REG_W    = 5;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [IR_W-1:0]     ir;
    logic [NPC_W-1:0]    npc;
    logic [REG_W-1:0]    dest;
    logic [RESULT_W-1:0] result;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ex_wb_buffer_if.sv
// EX dual result buses, writeback ports and the handshake between them.
interface ex_wb_buffer_if;
  import ex_wb_buffer_pkg::*;

  logic [IR_W-1:0]     ex_IR_in_1,       ex_IR_in_2;
  logic [NPC_W-1:0]    ex_NPC_in_1,      ex_NPC_in_2;
  logic [REG_W-1:0]    ex_dest_reg_in_1, ex_dest_reg_in_2;
  logic [RESULT_W-1:0] ex_result_in_1,   ex_result_in_2;
  logic                ex_valid_in_1,    ex_valid_in_2;
  logic                wb_stall_in;
  logic                stall_ex;

  logic [IR_W-1:0]     wb_IR_out_1,       wb_IR_out_2;
  logic [NPC_W-1:0]    wb_NPC_out_1,      wb_NPC_out_2;
  logic [REG_W-1:0]    wb_dest_reg_out_1, wb_dest_reg_out_2;
  logic [RESULT_W-1:0] wb_result_out_1,   wb_result_out_2;
  logic                wb_valid_out_1,    wb_valid_out_2;

  // Buffer side
  modport slave (
    input  ex_IR_in_1, ex_IR_in_2, ex_NPC_in_1, ex_NPC_in_2,
    input  ex_dest_reg_in_1, ex_dest_reg_in_2, ex_result_in_1, ex_result_in_2,
    input  ex_valid_in_1, ex_valid_in_2, wb_stall_in,
    output stall_ex,
    output wb_IR_out_1, wb_IR_out_2, wb_NPC_out_1, wb_NPC_out_2,
    output wb_dest_reg_out_1, wb_dest_reg_out_2, wb_result_out_1, wb_result_out_2,
    output wb_valid_out_1, wb_valid_out_2
  );

  // EX / writeback side
  modport master (
    output ex_IR_in_1, ex_IR_in_2, ex_NPC_in_1, ex_NPC_in_2,
    output ex_dest_reg_in_1, ex_dest_reg_in_2, ex_result_in_1, ex_result_in_2,
    output ex_valid_in_1, ex_valid_in_2, wb_stall_in,
    input  stall_ex,
    input  wb_IR_out_1, wb_IR_out_2, wb_NPC_out_1, wb_NPC_out_2,
    input  wb_dest_reg_out_1, wb_dest_reg_out_2, wb_result_out_1, wb_result_out_2,
    input  wb_valid_out_1, wb_valid_out_2
  );

endinterface

// File: rtl/wb_buffer_entry_ram.sv
// DEPTH-entry result storage: two write ports, two combinational read ports.
// The controller never writes both ports to the same address in one cycle.
module wb_buffer_entry_ram
  import ex_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_1,
  input  logic [AddrW-1:0] waddr_1,
  input  entry_t           wdata_1,
  input  logic             we_2,
  input  logic [AddrW-1:0] waddr_2,
  input  entry_t           wdata_2,
  input  logic [AddrW-1:0] raddr_1,
  output entry_t           rdata_1,
  input  logic [AddrW-1:0] raddr_2,
  output entry_t           rdata_2
);

  entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we_1) mem[waddr_1] <= wdata_1;
    if (we_2) mem[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/ex_wb_buffer.sv
// Circular buffer between the EX result buses and the two writeback ports.
// Accepts up to two results per cycle, retires the two oldest, stalls EX when < 2 free.
module ex_wb_buffer
  import ex_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic           clock,
  input logic           reset,
  ex_wb_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] enq_n, deq_n;
  logic [PtrW-1:0] waddr_2, raddr_2;
  logic            stall, acc_1, acc_2;
  logic            valid_1, valid_2;
  entry_t          wdata_1, wdata_2, rdata_1, rdata_2;

  always_comb begin
    stall = count_q > CntW'(DEPTH - 2);
    acc_1 = !stall && bus.ex_valid_in_1 && (bus.ex_dest_reg_in_1 != ZERO_REG);
    acc_2 = !stall && bus.ex_valid_in_2 && (bus.ex_dest_reg_in_2 != ZERO_REG);

    wdata_1 = '{ir: bus.ex_IR_in_1, npc: bus.ex_NPC_in_1,
                dest: bus.ex_dest_reg_in_1, result: bus.ex_result_in_1};
    wdata_2 = '{ir: bus.ex_IR_in_2, npc: bus.ex_NPC_in_2,
                dest: bus.ex_dest_reg_in_2, result: bus.ex_result_in_2};

    // Bus 2 slides down to tail when bus 1 carries nothing to keep.
    waddr_2 = acc_1 ? tail_q + PtrW'(1) : tail_q;
    raddr_2 = head_q + PtrW'(1);

    enq_n = CntW'(acc_1) + CntW'(acc_2);
    if (bus.wb_stall_in)              deq_n = '0;
    else if (count_q >= CntW'(2))     deq_n = CntW'(2);
    else                              deq_n = count_q;

    tail_d  = tail_q + enq_n[PtrW-1:0];
    head_d  = head_q + deq_n[PtrW-1:0];
    count_d = count_q + enq_n - deq_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wb_buffer_entry_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .we_1    (acc_1),
    .waddr_1 (tail_q),
    .wdata_1 (wdata_1),
    .we_2    (acc_2),
    .waddr_2 (waddr_2),
    .wdata_2 (wdata_2),
    .raddr_1 (head_q),
    .rdata_1 (rdata_1),
    .raddr_2 (raddr_2),
    .rdata_2 (rdata_2)
  );

  always_comb begin
    valid_1 = count_q != '0;
    valid_2 = count_q >= CntW'(2);

    bus.stall_ex       = stall;
    bus.wb_valid_out_1 = valid_1;
    bus.wb_valid_out_2 = valid_2;

    bus.wb_IR_out_1       = valid_1 ? rdata_1.ir     : '0;
    bus.wb_NPC_out_1      = valid_1 ? rdata_1.npc    : '0;
    bus.wb_dest_reg_out_1 = valid_1 ? rdata_1.dest   : '0;
    bus.wb_result_out_1   = valid_1 ? rdata_1.result : '0;

    bus.wb_IR_out_2       = valid_2 ? rdata_2.ir     : '0;
    bus.wb_NPC_out_2      = valid_2 ? rdata_2.npc    : '0;
    bus.wb_dest_reg_out_2 = valid_2 ? rdata_2.dest   : '0;
    bus.wb_result_out_2   = valid_2 ? rdata_2.result : '0;
  end

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Directed bench for ex_wb_buffer (DEPTH = 8) with a queue scoreboard for the wrap run.
module tb_ex_wb_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_wb_buffer_if ifc ();

  ex_wb_buffer #(
    .DEPTH (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifc.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic [4:0] d, input logic [63:0] r);
    ifc.ex_valid_in_1    = v;
    ifc.ex_dest_reg_in_1 = d;
    ifc.ex_result_in_1   = r;
    ifc.ex_IR_in_1       = 32'hA000_0000 | r[31:0];
    ifc.ex_NPC_in_1      = 64'h1000 + r;
  endtask

  task automatic drv2(input logic v, input logic [4:0] d, input logic [63:0] r);
    ifc.ex_valid_in_2    = v;
    ifc.ex_dest_reg_in_2 = d;
    ifc.ex_result_in_2   = r;
    ifc.ex_IR_in_2       = 32'hB000_0000 | r[31:0];
    ifc.ex_NPC_in_2      = 64'h2000 + r;
  endtask

  // Compare both ports and stall_ex against the scoreboard queue.
  task automatic chk_q(input string tag, input logic [63:0] q[$]);
    int n;
    n = q.size();
    chk({tag, "_v1"},    64'(ifc.wb_valid_out_1), 64'(n >= 1));
    chk({tag, "_r1"},    ifc.wb_result_out_1, (n >= 1) ? q[0] : 64'h0);
    chk({tag, "_v2"},    64'(ifc.wb_valid_out_2), 64'(n >= 2));
    chk({tag, "_r2"},    ifc.wb_result_out_2, (n >= 2) ? q[1] : 64'h0);
    chk({tag, "_stall"}, 64'(ifc.stall_ex), 64'(n > 6));
  endtask

  logic [63:0] q[$];
  int          seq;
  logic        ws;
  logic        m_stall;
  int          pop;

  initial begin
    ifc.wb_stall_in = 1'b0;
    drv1(1'b1, 5'd9, 64'h99);
    drv2(1'b0, 5'd0, 64'h0);

    // Reset; input presented during reset must not be captured
    tick();
    rst = 1'b0;
    drv1(1'b0, 5'd0, 64'h0);
    chk("rst_v1",    64'(ifc.wb_valid_out_1), 64'h0);
    chk("rst_v2",    64'(ifc.wb_valid_out_2), 64'h0);
    chk("rst_stall", 64'(ifc.stall_ex), 64'h0);
    chk("rst_r1",    ifc.wb_result_out_1, 64'h0);

    // Pair on both buses, visible next cycle, drained the cycle after
    drv1(1'b1, 5'd3, 64'h11);
    drv2(1'b1, 5'd4, 64'h22);
    tick();
    drv1(1'b0, 5'd0, 64'h0);
    drv2(1'b0, 5'd0, 64'h0);
    chk("pair_v1",  64'(ifc.wb_valid_out_1), 64'h1);
    chk("pair_d1",  64'(ifc.wb_dest_reg_out_1), 64'd3);
    chk("pair_r1",  ifc.wb_result_out_1, 64'h11);
    chk("pair_ir1", 64'(ifc.wb_IR_out_1), 64'hA000_0011);
    chk("pair_v2",  64'(ifc.wb_valid_out_2), 64'h1);
    chk("pair_d2",  64'(ifc.wb_dest_reg_out_2), 64'd4);
    chk("pair_r2",  ifc.wb_result_out_2, 64'h22);
    chk("pair_np2", ifc.wb_NPC_out_2, 64'h2022);
    tick();
    chk("drain_v1", 64'(ifc.wb_valid_out_1), 64'h0);
    chk("drain_v2", 64'(ifc.wb_valid_out_2), 64'h0);
    chk("drain_r1", ifc.wb_result_out_1, 64'h0);

    // Only bus 2 valid: lands on port 1
    drv2(1'b1, 5'd7, 64'h55);
    tick();
    drv2(1'b0, 5'd0, 64'h0);
    chk("b2_v1", 64'(ifc.wb_valid_out_1), 64'h1);
    chk("b2_d1", 64'(ifc.wb_dest_reg_out_1), 64'd7);
    chk("b2_r1", ifc.wb_result_out_1, 64'h55);
    chk("b2_v2", 64'(ifc.wb_valid_out_2), 64'h0);
    chk("b2_r2", ifc.wb_result_out_2, 64'h0);
    tick();

    // Zero-register destination on bus 1 is dropped
    ifc.wb_stall_in = 1'b1;
    drv1(1'b1, 5'd31, 64'h66);
    drv2(1'b1, 5'd5,  64'h77);
    tick();
    drv1(1'b0, 5'd0, 64'h0);
    drv2(1'b0, 5'd0, 64'h0);
    chk("z_v1", 64'(ifc.wb_valid_out_1), 64'h1);
    chk("z_d1", 64'(ifc.wb_dest_reg_out_1), 64'd5);
    chk("z_r1", ifc.wb_result_out_1, 64'h77);
    chk("z_v2", 64'(ifc.wb_valid_out_2), 64'h0);
    ifc.wb_stall_in = 1'b0;
    tick();
    chk("z_empty", 64'(ifc.wb_valid_out_1), 64'h0);

    // Fill under writeback stall: stall_ex only once count reaches 8
    ifc.wb_stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv1(1'b1, 5'(10 + 2 * k), 64'(32'h100 + 2 * k));
      drv2(1'b1, 5'(11 + 2 * k), 64'(32'h101 + 2 * k));
      tick();
      chk($sformatf("fill_stall%0d", k), 64'(ifc.stall_ex), (k == 3) ? 64'h1 : 64'h0);
    end
    drv1(1'b1, 5'd20, 64'h200);
    drv2(1'b1, 5'd21, 64'h201);
    tick();
    chk("full_stall", 64'(ifc.stall_ex), 64'h1);
    chk("full_r1",    ifc.wb_result_out_1, 64'h100);
    chk("full_r2",    ifc.wb_result_out_2, 64'h101);
    drv1(1'b0, 5'd0, 64'h0);
    drv2(1'b0, 5'd0, 64'h0);
    ifc.wb_stall_in = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("rel_r1_%0d", k), ifc.wb_result_out_1, 64'(32'h100 + 2 * k));
      chk($sformatf("rel_r2_%0d", k), ifc.wb_result_out_2, 64'(32'h101 + 2 * k));
      chk($sformatf("rel_stall%0d", k), 64'(ifc.stall_ex), 64'h0);
    end
    tick();
    chk("rel_empty", 64'(ifc.wb_valid_out_1), 64'h0);

    // Alternating writeback stall: forces pointer wrap, checked against a queue
    seq = 0;
    for (int i = 0; i < 20; i++) begin
      chk_q($sformatf("wrap%0d", i), q);
      ws = 1'(i % 2);
      ifc.wb_stall_in = ws;
      m_stall = q.size() > 6;
      drv1(1'b1, 5'((seq % 29) + 1), 64'(32'h300 + seq));
      drv2(1'b1, (i % 5 == 0) ? 5'd31 : 5'(((seq + 1) % 29) + 1), 64'(32'h300 + seq + 1));
      pop = ws ? 0 : ((q.size() >= 2) ? 2 : q.size());
      repeat (pop) void'(q.pop_front());
      if (!m_stall) begin
        q.push_back(64'(32'h300 + seq));
        if (i % 5 != 0) q.push_back(64'(32'h300 + seq + 1));
        seq += 2;
      end
      tick();
    end
    drv1(1'b0, 5'd0, 64'h0);
    drv2(1'b0, 5'd0, 64'h0);
    ifc.wb_stall_in = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk_q($sformatf("wdrain%0d", j), q);
      pop = (q.size() >= 2) ? 2 : q.size();
      repeat (pop) void'(q.pop_front());
      tick();
    end
    chk("wrap_empty", 64'(ifc.wb_valid_out_1), 64'h0);

    // Reset with 5 entries buffered discards all of them
    ifc.wb_stall_in = 1'b1;
    drv1(1'b1, 5'd1, 64'h400);
    drv2(1'b1, 5'd2, 64'h401);
    tick();
    drv1(1'b1, 5'd3, 64'h402);
    drv2(1'b1, 5'd4, 64'h403);
    tick();
    drv1(1'b1, 5'd5, 64'h404);
    drv2(1'b0, 5'd0, 64'h0);
    tick();
    chk("pre_r1", ifc.wb_result_out_1, 64'h400);
    rst = 1'b1;
    drv1(1'b1, 5'd8, 64'h500);
    tick();
    rst = 1'b0;
    drv1(1'b0, 5'd0, 64'h0);
    chk("mrst_v1",    64'(ifc.wb_valid_out_1), 64'h0);
    chk("mrst_v2",    64'(ifc.wb_valid_out_2), 64'h0);
    chk("mrst_r1",    ifc.wb_result_out_1, 64'h0);
    chk("mrst_d1",    64'(ifc.wb_dest_reg_out_1), 64'h0);
    chk("mrst_r2",    ifc.wb_result_out_2, 64'h0);
    chk("mrst_stall", 64'(ifc.stall_ex), 64'h0);
    drv1(1'b1, 5'd6, 64'h600);
    tick();
    drv1(1'b0, 5'd0, 64'h0);
    chk("post_v1", 64'(ifc.wb_valid_out_1), 64'h1);
    chk("post_r1", ifc.wb_result_out_1, 64'h600);
    chk("post_v2", 64'(ifc.wb_valid_out_2), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
